// File: rtl/ddr3_axi_memtest.sv
// AXI4 memory test master: writes an address-derived pattern over a region in
// fixed-length INCR bursts, reads it back and counts every mismatching beat.
module ddr3_axi_memtest #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          NUM_BURSTS = 256,
    parameter int          BURST_LEN  = 16,
    parameter logic [3:0]  AXI_ID     = 4'h0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [15:0] error_count_o,
    output logic [31:0] first_err_addr_o,
    output logic        outport_awvalid_o,
    output logic [31:0] outport_awaddr_o,
    output logic [3:0]  outport_awid_o,
    output logic [7:0]  outport_awlen_o,
    output logic [1:0]  outport_awburst_o,
    input  logic        outport_awready_i,
    output logic        outport_wvalid_o,
    output logic [31:0] outport_wdata_o,
    output logic [3:0]  outport_wstrb_o,
    output logic        outport_wlast_o,
    input  logic        outport_wready_i,
    input  logic        outport_bvalid_i,
    input  logic [1:0]  outport_bresp_i,
    input  logic [3:0]  outport_bid_i,
    output logic        outport_bready_o,
    output logic        outport_arvalid_o,
    output logic [31:0] outport_araddr_o,
    output logic [3:0]  outport_arid_o,
    output logic [7:0]  outport_arlen_o,
    output logic [1:0]  outport_arburst_o,
    input  logic        outport_arready_i,
    input  logic        outport_rvalid_i,
    input  logic [31:0] outport_rdata_i,
    input  logic [1:0]  outport_rresp_i,
    input  logic [3:0]  outport_rid_i,
    input  logic        outport_rlast_i,
    output logic        outport_rready_o
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_ADDR = 3'd1;
    localparam logic [2:0] WR_DATA = 3'd2;
    localparam logic [2:0] WR_RESP = 3'd3;
    localparam logic [2:0] RD_ADDR = 3'd4;
    localparam logic [2:0] RD_DATA = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;

    localparam logic [31:0] PATTERN     = 32'h5A5A_A5A5;
    localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 4);
    localparam logic [7:0]  AXLEN       = 8'(BURST_LEN - 1);
    localparam logic [8:0]  LAST_BEAT   = 9'(BURST_LEN - 1);
    localparam logic [15:0] LAST_BURST  = 16'(NUM_BURSTS - 1);

    logic [2:0]  state;
    logic [15:0] burst_idx;
    logic [8:0]  beat_idx;
    logic [31:0] burst_addr;
    logic [31:0] beat_addr;
    logic        last_beat;
    logic        last_burst;
    logic        err_event;
    logic [31:0] err_addr;
    logic [15:0] error_count_next;

    assign last_beat  = (beat_idx == LAST_BEAT);
    assign last_burst = (burst_idx == LAST_BURST);

    // A write error is blamed on the burst address, a read error on the beat address.
    always_comb begin
        err_event = 1'b0;
        err_addr  = burst_addr;
        if (state == WR_RESP && outport_bvalid_i) begin
            err_event = (outport_bresp_i != 2'b00) || (outport_bid_i != AXI_ID);
        end else if (state == RD_DATA && outport_rvalid_i) begin
            err_addr  = beat_addr;
            err_event = (outport_rdata_i != (beat_addr ^ PATTERN)) ||
                        (outport_rresp_i != 2'b00) ||
                        (outport_rid_i != AXI_ID) ||
                        (outport_rlast_i != last_beat);
        end
    end

    assign error_count_next = (err_event && error_count_o != 16'hFFFF) ?
                              error_count_o + 16'd1 : error_count_o;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state             <= IDLE;
            burst_idx         <= '0;
            beat_idx          <= '0;
            burst_addr        <= '0;
            beat_addr         <= '0;
            busy_o            <= 1'b0;
            done_o            <= 1'b0;
            pass_o            <= 1'b0;
            error_count_o     <= '0;
            first_err_addr_o  <= '0;
            outport_awvalid_o <= 1'b0;
            outport_awaddr_o  <= '0;
            outport_awid_o    <= '0;
            outport_awlen_o   <= '0;
            outport_awburst_o <= '0;
            outport_wvalid_o  <= 1'b0;
            outport_wdata_o   <= '0;
            outport_wstrb_o   <= '0;
            outport_wlast_o   <= 1'b0;
            outport_bready_o  <= 1'b0;
            outport_arvalid_o <= 1'b0;
            outport_araddr_o  <= '0;
            outport_arid_o    <= '0;
            outport_arlen_o   <= '0;
            outport_arburst_o <= '0;
            outport_rready_o  <= 1'b0;
        end else begin
            error_count_o <= error_count_next;
            if (err_event && error_count_o == 16'd0) begin
                first_err_addr_o <= err_addr;
            end
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state             <= WR_ADDR;
                        burst_idx         <= '0;
                        burst_addr        <= BASE_ADDR;
                        error_count_o     <= '0;
                        first_err_addr_o  <= '0;
                        busy_o            <= 1'b1;
                        done_o            <= 1'b0;
                        pass_o            <= 1'b0;
                        outport_awvalid_o <= 1'b1;
                        outport_awaddr_o  <= BASE_ADDR;
                        outport_awid_o    <= AXI_ID;
                        outport_awlen_o   <= AXLEN;
                        outport_awburst_o <= 2'b01;
                        outport_wstrb_o   <= 4'hF;
                        outport_arid_o    <= AXI_ID;
                        outport_arlen_o   <= AXLEN;
                        outport_arburst_o <= 2'b01;
                    end
                end
                WR_ADDR: begin
                    if (outport_awready_i) begin
                        outport_awvalid_o <= 1'b0;
                        outport_wvalid_o  <= 1'b1;
                        outport_wdata_o   <= burst_addr ^ PATTERN;
                        outport_wlast_o   <= (LAST_BEAT == 9'd0);
                        beat_idx          <= '0;
                        beat_addr         <= burst_addr;
                        state             <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (outport_wready_i) begin
                        if (last_beat) begin
                            outport_wvalid_o <= 1'b0;
                            outport_wlast_o  <= 1'b0;
                            outport_bready_o <= 1'b1;
                            state            <= WR_RESP;
                        end else begin
                            beat_idx        <= beat_idx + 9'd1;
                            beat_addr       <= beat_addr + 32'd4;
                            outport_wdata_o <= (beat_addr + 32'd4) ^ PATTERN;
                            outport_wlast_o <= ((beat_idx + 9'd1) == LAST_BEAT);
                        end
                    end
                end
                WR_RESP: begin
                    if (outport_bvalid_i) begin
                        outport_bready_o <= 1'b0;
                        if (last_burst) begin
                            burst_idx         <= '0;
                            burst_addr        <= BASE_ADDR;
                            outport_arvalid_o <= 1'b1;
                            outport_araddr_o  <= BASE_ADDR;
                            state             <= RD_ADDR;
                        end else begin
                            burst_idx         <= burst_idx + 16'd1;
                            burst_addr        <= burst_addr + BURST_BYTES;
                            outport_awvalid_o <= 1'b1;
                            outport_awaddr_o  <= burst_addr + BURST_BYTES;
                            state             <= WR_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (outport_arready_i) begin
                        outport_arvalid_o <= 1'b0;
                        outport_rready_o  <= 1'b1;
                        beat_idx          <= '0;
                        beat_addr         <= burst_addr;
                        state             <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    // Burst end is decided by the beat counter; rlast is only checked.
                    if (outport_rvalid_i) begin
                        if (last_beat) begin
                            outport_rready_o <= 1'b0;
                            if (last_burst) begin
                                state  <= DONE;
                                busy_o <= 1'b0;
                                done_o <= 1'b1;
                                pass_o <= (error_count_next == 16'd0);
                            end else begin
                                burst_idx         <= burst_idx + 16'd1;
                                burst_addr        <= burst_addr + BURST_BYTES;
                                outport_arvalid_o <= 1'b1;
                                outport_araddr_o  <= burst_addr + BURST_BYTES;
                                state             <= RD_ADDR;
                            end
                        end else begin
                            beat_idx  <= beat_idx + 9'd1;
                            beat_addr <= beat_addr + 32'd4;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_axi_memtest.sv
// Scoreboard bench for ddr3_axi_memtest: an AXI slave memory model with stall
// and fault injection, expected traffic queued at start and checked by a monitor.
module tb_ddr3_axi_memtest;

    localparam int         NB = 4;
    localparam int         BL = 4;
    localparam logic [3:0] ID = 4'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, pass;
    logic [15:0] error_count;
    logic [31:0] first_err_addr;
    logic        awvalid, awready = 1'b0;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic        wvalid, wready = 1'b0, wlast;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid = 1'b0, bready;
    logic [1:0]  bresp = 2'b00;
    logic [3:0]  bid = 4'h0;
    logic        arvalid, arready = 1'b0;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic        rvalid = 1'b0, rready, rlast = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = 2'b00;
    logic [3:0]  rid = 4'h0;

    int n_checks = 0;
    int n_fail = 0;

    // Fault-injection and stall knobs, set by the main sequence.
    logic        stall_en = 1'b0;
    logic        flip_en = 1'b0;
    logic [31:0] flip_addr = '0;
    logic        rresp_err_en = 1'b0;
    logic [31:0] rresp_err_addr = '0;
    int          bresp_err_burst = -1;
    int          rlast_miss_burst = -1;

    logic [31:0] mem [16];
    logic [31:0] exp_aw_q[$];
    logic [32:0] exp_w_q[$];
    logic [31:0] exp_ar_q[$];
    logic [48:0] exp_res_q[$];

    // Hand-computed low bytes of addr ^ 32'h5A5AA5A5 for addresses 0x00..0x3C.
    logic [7:0]  wdata_lo [16] = '{8'hA5, 8'hA1, 8'hAD, 8'hA9, 8'hB5, 8'hB1, 8'hBD, 8'hB9,
                                   8'h85, 8'h81, 8'h8D, 8'h89, 8'h95, 8'h91, 8'h9D, 8'h99};
    logic [31:0] burst_addr_tab [4] = '{32'h00, 32'h10, 32'h20, 32'h30};

    ddr3_axi_memtest #(
        .BASE_ADDR (32'h0000_0000),
        .NUM_BURSTS(NB),
        .BURST_LEN (BL),
        .AXI_ID    (ID)
    ) dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .start_i           (start),
        .busy_o            (busy),
        .done_o            (done),
        .pass_o            (pass),
        .error_count_o     (error_count),
        .first_err_addr_o  (first_err_addr),
        .outport_awvalid_o (awvalid),
        .outport_awaddr_o  (awaddr),
        .outport_awid_o    (awid),
        .outport_awlen_o   (awlen),
        .outport_awburst_o (awburst),
        .outport_awready_i (awready),
        .outport_wvalid_o  (wvalid),
        .outport_wdata_o   (wdata),
        .outport_wstrb_o   (wstrb),
        .outport_wlast_o   (wlast),
        .outport_wready_i  (wready),
        .outport_bvalid_i  (bvalid),
        .outport_bresp_i   (bresp),
        .outport_bid_i     (bid),
        .outport_bready_o  (bready),
        .outport_arvalid_o (arvalid),
        .outport_araddr_o  (araddr),
        .outport_arid_o    (arid),
        .outport_arlen_o   (arlen),
        .outport_arburst_o (arburst),
        .outport_arready_i (arready),
        .outport_rvalid_i  (rvalid),
        .outport_rdata_i   (rdata),
        .outport_rresp_i   (rresp),
        .outport_rid_i     (rid),
        .outport_rlast_i   (rlast),
        .outport_rready_o  (rready)
    );

    initial forever #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic int draw();
        return stall_en ? int'($urandom_range(0, 5)) : 0;
    endfunction

    // Slave memory model: decides readies/responses on the falling edge for the next rising edge.
    initial begin : slave
        int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
        int          w_beat = 0, r_beat = 0, r_burst = 0;
        logic        b_pending = 1'b0, b_taken = 1'b0, r_active = 1'b0, r_taken = 1'b0;
        logic [31:0] w_addr = '0, r_addr = '0, b_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
                aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
                w_beat = 0; r_beat = 0; b_pending = 1'b0; b_taken = 1'b0;
                r_active = 1'b0; r_taken = 1'b0;
                for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
                continue;
            end
            if (b_taken) bvalid = 1'b0;
            if (b_pending && !bvalid) begin
                if (b_wait > 0) b_wait--;
                else begin
                    bvalid    = 1'b1;
                    bresp     = (int'(b_addr / 16) == bresp_err_burst) ? 2'b10 : 2'b00;
                    bid       = ID;
                    b_pending = 1'b0;
                end
            end
            b_taken = bvalid && bready;
            if (r_taken) begin
                rvalid = 1'b0;
                r_beat++;
                r_addr = r_addr + 32'd4;
                if (r_beat == BL) r_active = 1'b0;
                r_wait = draw();
            end
            if (r_active && !rvalid) begin
                if (r_wait > 0) r_wait--;
                else begin
                    rvalid = 1'b1;
                    rdata  = mem[r_addr[5:2]] ^ ((flip_en && r_addr == flip_addr) ? 32'd1 : 32'd0);
                    rresp  = (rresp_err_en && r_addr == rresp_err_addr) ? 2'b10 : 2'b00;
                    rid    = ID;
                    rlast  = (r_beat == BL - 1) && (r_burst != rlast_miss_burst);
                end
            end
            r_taken = rvalid && rready;
            if (wvalid) begin
                if (w_wait > 0) begin wready = 1'b0; w_wait--; end
                else begin
                    wready = 1'b1;
                    mem[w_addr[5:2]] = wdata;
                    w_addr = w_addr + 32'd4;
                    w_beat++;
                    if (w_beat == BL) begin b_pending = 1'b1; b_wait = draw(); w_beat = 0; end
                    w_wait = draw();
                end
            end else wready = 1'b0;
            if (awvalid) begin
                if (aw_wait > 0) begin awready = 1'b0; aw_wait--; end
                else begin awready = 1'b1; w_addr = awaddr; b_addr = awaddr; w_beat = 0; aw_wait = draw(); end
            end else awready = 1'b0;
            if (arvalid) begin
                if (ar_wait > 0) begin arready = 1'b0; ar_wait--; end
                else begin
                    arready = 1'b1; r_active = 1'b1; r_addr = araddr; r_burst = int'(araddr / 16);
                    r_beat = 0; r_wait = draw(); ar_wait = draw();
                end
            end else arready = 1'b0;
        end
    end

    // Monitor: pops the scoreboard on every handshake and on each rising done.
    initial begin : monitor
        logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
        logic        p_done = 0, p_live = 0, p_rhs = 0, aw_open = 0, p_wlast = 0;
        logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
        logic [32:0] ew;
        logic [48:0] er;
        forever begin
            @(negedge clk); #1;
            if (!rst_n) begin
                p_awv = 0; p_wv = 0; p_arv = 0; p_done = 0; p_live = 0; p_rhs = 0; aw_open = 0;
                continue;
            end
            if (p_live && p_awv && !p_awr) begin
                checkOutput("aw_valid_hold", 32'(awvalid), 32'd1);
                checkOutput("aw_addr_hold", awaddr, p_awaddr);
            end
            if (p_live && p_wv && !p_wr) begin
                checkOutput("w_valid_hold", 32'(wvalid), 32'd1);
                checkOutput("w_data_hold", {wdata[31:1], wdata[0] ^ wlast ^ p_wlast}, p_wdata);
            end
            if (p_live && p_arv && !p_arr) begin
                checkOutput("ar_valid_hold", 32'(arvalid), 32'd1);
                checkOutput("ar_addr_hold", araddr, p_araddr);
            end
            if (wvalid) checkOutput("w_after_aw", 32'(aw_open), 32'd1);
            if (awvalid && awready) begin
                checkOutput("aw_expected", 32'(exp_aw_q.size() > 0), 32'd1);
                if (exp_aw_q.size() > 0) checkOutput("awaddr", awaddr, exp_aw_q.pop_front());
                checkOutput("aw_len_burst_id", {20'd0, awlen, awburst, awid[1:0]}, {20'd0, 8'd3, 2'b01, ID[1:0]});
                aw_open = 1'b1;
            end
            if (wvalid && wready) begin
                checkOutput("w_expected", 32'(exp_w_q.size() > 0), 32'd1);
                if (exp_w_q.size() > 0) begin
                    ew = exp_w_q.pop_front();
                    checkOutput("wdata", wdata, ew[31:0]);
                    checkOutput("wlast_wstrb", {27'd0, wlast, wstrb}, {27'd0, ew[32], 4'hF});
                end
                if (wlast) aw_open = 1'b0;
            end
            if (arvalid && arready) begin
                checkOutput("ar_expected", 32'(exp_ar_q.size() > 0), 32'd1);
                if (exp_ar_q.size() > 0) checkOutput("araddr", araddr, exp_ar_q.pop_front());
                checkOutput("ar_len_burst_id", {20'd0, arlen, arburst, arid[1:0]}, {20'd0, 8'd3, 2'b01, ID[1:0]});
            end
            if (done && !p_done) begin
                checkOutput("result_expected", 32'(exp_res_q.size() > 0), 32'd1);
                if (exp_res_q.size() > 0) begin
                    er = exp_res_q.pop_front();
                    checkOutput("error_count", 32'(error_count), 32'(er[47:32]));
                    checkOutput("first_err_addr", first_err_addr, er[31:0]);
                    checkOutput("pass", 32'(pass), 32'(er[48]));
                end
                checkOutput("busy_at_done", 32'(busy), 32'd0);
                checkOutput("done_latency", 32'(p_rhs), 32'd1);
            end
            p_rhs = rvalid && rready;
            p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
            p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wlast = wlast;
            p_arv = arvalid; p_arr = arready; p_araddr = araddr;
            p_done = done; p_live = 1'b1;
        end
    end

    task automatic check_all_zero(input string name);
        checkOutput({name, "_ctrl"}, {24'd0, awvalid, wvalid, bready, arvalid, rready, busy, done, pass}, 32'd0);
        checkOutput({name, "_awaddr"}, awaddr, 32'd0);
        checkOutput({name, "_wdata"}, wdata, 32'd0);
        checkOutput({name, "_araddr"}, araddr, 32'd0);
        checkOutput({name, "_count"}, {error_count, awlen, arlen}, 32'd0);
        checkOutput({name, "_first"}, first_err_addr, 32'd0);
        checkOutput({name, "_misc"}, {18'd0, awid, arid, awburst, arburst, wstrb, wlast, 1'b0}, 32'd0);
    endtask

    // Queues the full expected traffic and result, then issues start.
    task automatic applyStimulus(input logic [15:0] cnt, input logic [31:0] first, input logic exp_pass, input int hold);
        for (int b = 0; b < NB; b++) begin
            exp_aw_q.push_back(burst_addr_tab[b]);
            exp_ar_q.push_back(burst_addr_tab[b]);
            for (int k = 0; k < BL; k++)
                exp_w_q.push_back({(k == BL - 1), 24'h5A5AA5, wdata_lo[b * BL + k]});
        end
        exp_res_q.push_back({exp_pass, cnt, first});
        @(negedge clk); #2 start = 1'b1;
        @(negedge clk); #2;
        checkOutput("start_state", {27'd0, busy, done, pass, awvalid, wvalid}, {27'd0, 5'b10010});
        checkOutput("start_cleared", {16'd0, error_count}, 32'd0);
        checkOutput("start_first_cleared", first_err_addr, 32'd0);
        repeat (hold) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int cyc = 0;
        while (!done && cyc < 3000) begin @(negedge clk); cyc++; end
        checkOutput({name, "_done_seen"}, 32'(done), 32'd1);
        repeat (3) @(negedge clk);
        #2 checkOutput({name, "_sb_empty"}, 32'(exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size() + exp_res_q.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk); #2 rst_n = 1'b0;
        #1 check_all_zero("reset_async");
        @(negedge clk); #2;
        exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete(); exp_res_q.delete();
        rst_n = 1'b1;
    endtask

    initial begin : main
        int cyc;
        $display("[TB] start");
        repeat (2) @(negedge clk);
        #2 check_all_zero("reset");
        rst_n = 1'b1;

        $display("[TB] clean pass");
        applyStimulus(16'd0, 32'h0, 1'b1, 0);
        wait_done("clean");

        $display("[TB] rdata bit flip at 0x24");
        flip_en = 1'b1; flip_addr = 32'h24;
        applyStimulus(16'd1, 32'h24, 1'b0, 0);
        wait_done("flip");
        flip_en = 1'b0;

        $display("[TB] restart from DONE");
        applyStimulus(16'd0, 32'h0, 1'b1, 0);
        wait_done("restart");

        $display("[TB] random stalls");
        stall_en = 1'b1;
        applyStimulus(16'd0, 32'h0, 1'b1, 0);
        wait_done("stall");
        stall_en = 1'b0;

        $display("[TB] response errors");
        bresp_err_burst = 2; rresp_err_en = 1'b1; rresp_err_addr = 32'h08; rlast_miss_burst = 3;
        applyStimulus(16'd3, 32'h20, 1'b0, 0);
        wait_done("resp_err");
        bresp_err_burst = -1; rresp_err_en = 1'b0; rlast_miss_burst = -1;

        $display("[TB] reset mid write burst 1");
        applyStimulus(16'd0, 32'h0, 1'b1, 0);
        cyc = 0;
        while (!(wvalid && awaddr == 32'h10) && cyc < 500) begin @(negedge clk); #2; cyc++; end
        checkOutput("mid_burst_reached", 32'(wvalid && awaddr == 32'h10), 32'd1);
        pulse_reset();
        applyStimulus(16'd0, 32'h0, 1'b1, 0);
        wait_done("after_reset");

        $display("[TB] start held while busy");
        applyStimulus(16'd0, 32'h0, 1'b1, 30);
        wait_done("held_start");

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
